// File: rtl/m_proc_mc_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset core: opcodes, FSM
// state encoding, ALU control codes and the funct3/funct7 field values.
package pkg_proc_mc;

  // Major opcodes of the supported instruction subset
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  // funct3 values used for ALU selection and branch condition
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  // funct7 value that turns an R-type add into a subtract
  localparam logic [6:0] F7_SUB = 7'b0100000;

  // Instruction sequencing states
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MA   = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  // ALU operation select
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_ctrl_e;

  // Map an R-type funct3/funct7 pair onto an ALU operation; anything not in
  // the subset falls back to add.
  function automatic alu_ctrl_e f_r_alu_ctrl(input logic [2:0] f3, input logic [6:0] f7);
    alu_ctrl_e ctrl;
    case (f3)
      F3_ADD_SUB: ctrl = (f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
      F3_SLT:     ctrl = ALU_SLT;
      F3_OR:      ctrl = ALU_OR;
      F3_AND:     ctrl = ALU_AND;
      default:    ctrl = ALU_ADD;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/m_proc_mc_alu.sv
// Single shared combinational ALU of the multi-cycle core. Computes the
// selected operation and an equality flag used by the branch logic.
module m_mc_alu
  import pkg_proc_mc::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_ctrl_e   ctrl,
  output logic [31:0] out,
  output logic        eq
);

  // Operation select; slt is a signed compare yielding 0 or 1
  always_comb begin
    out = a + b;
    case (ctrl)
      ALU_ADD: out = a + b;
      ALU_SUB: out = a - b;
      ALU_AND: out = a & b;
      ALU_OR:  out = a | b;
      ALU_SLT: out = {31'b0, ($signed(a) < $signed(b))};
      default: out = a + b;
    endcase
    eq = (a == b);
  end

endmodule

// File: rtl/m_proc_mc.sv
// Multi-cycle RV32I-subset processor. Each instruction walks the
// IF/ID/EX/MA/WB state machine, sharing one ALU through registered
// intermediates. A write-back to HALT_REG parks the core in S_HALT.
module m_proc_mc
  import pkg_proc_mc::*;
#(
  parameter int          IMEM_DEPTH = 64,
  parameter int          DMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          HALT_REG   = 30
)(
  input  logic        w_clk,
  input  logic        w_rst_n,
  output logic [31:0] w_pc,
  output logic        w_retire,
  output logic [31:0] w_instret,
  output logic        w_halt
);

  localparam int         IMEM_AW  = $clog2(IMEM_DEPTH);
  localparam int         DMEM_AW  = $clog2(DMEM_DEPTH);
  localparam logic [4:0] HALT_IDX = 5'(HALT_REG);

  // Instruction memory is preloaded from outside; data memory is written by sw
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] rf_q [32];

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] instret_q, instret_d;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_dec;
  logic [31:0] rs1_val, rs2_val;
  logic [IMEM_AW-1:0] imem_idx;
  logic [DMEM_AW-1:0] dmem_idx;

  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_eq;
  alu_ctrl_e   alu_ctrl;
  logic        branch_taken;

  logic        retire;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        dmem_we;

  assign opcode   = ir_q[6:0];
  assign rd       = ir_q[11:7];
  assign funct3   = ir_q[14:12];
  assign rs1      = ir_q[19:15];
  assign rs2      = ir_q[24:20];
  assign funct7   = ir_q[31:25];
  assign imem_idx = pc_q[IMEM_AW+1:2];
  assign dmem_idx = alu_q[DMEM_AW+1:2];

  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : rf_q[rs2];

  // Immediate extraction for the I/S/B/U/J formats, chosen by opcode
  always_comb begin
    imm_dec = {{20{ir_q[31]}}, ir_q[31:20]};
    case (opcode)
      OP_SW:   imm_dec = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OP_BR:   imm_dec = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      OP_LUI:  imm_dec = {ir_q[31:12], 12'b0};
      OP_JAL:  imm_dec = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default: imm_dec = {{20{ir_q[31]}}, ir_q[31:20]};
    endcase
  end

  // ALU operand and operation selection; lui adds its immediate to zero
  always_comb begin
    alu_a    = a_q;
    alu_b    = imm_q;
    alu_ctrl = ALU_ADD;
    case (opcode)
      OP_R: begin
        alu_b    = b_q;
        alu_ctrl = f_r_alu_ctrl(funct3, funct7);
      end
      OP_BR: begin
        alu_b    = b_q;
        alu_ctrl = ALU_SUB;
      end
      OP_LUI:  alu_a = 32'h0;
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  m_mc_alu u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .ctrl (alu_ctrl),
    .out  (alu_out),
    .eq   (alu_eq)
  );

  // Branch condition from the ALU equality flag
  always_comb begin
    case (funct3)
      F3_BEQ:  branch_taken = alu_eq;
      F3_BNE:  branch_taken = !alu_eq;
      default: branch_taken = 1'b0;
    endcase
  end

  // Next-state and datapath control for the instruction sequencer
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    retire   = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = alu_q;
    dmem_we  = 1'b0;

    case (state_q)
      S_IF: begin
        ir_d    = imem[imem_idx];
        state_d = S_ID;
      end
      S_ID: begin
        a_d     = rs1_val;
        b_d     = rs2_val;
        imm_d   = imm_dec;
        state_d = S_EX;
      end
      S_EX: begin
        alu_d = alu_out;
        case (opcode)
          OP_R, OP_I, OP_LUI, OP_JAL: state_d = S_WB;
          OP_LW, OP_SW:               state_d = S_MA;
          OP_BR: begin
            pc_d    = branch_taken ? (pc_q + imm_q) : (pc_q + 32'd4);
            retire  = 1'b1;
            state_d = S_IF;
          end
          default: begin
            pc_d    = pc_q + 32'd4;
            retire  = 1'b1;
            state_d = S_IF;
          end
        endcase
      end
      S_MA: begin
        if (opcode == OP_LW) begin
          mdr_d   = dmem[dmem_idx];
          state_d = S_WB;
        end else begin
          dmem_we = 1'b1;
          pc_d    = pc_q + 32'd4;
          retire  = 1'b1;
          state_d = S_IF;
        end
      end
      S_WB: begin
        rf_we = (rd != 5'd0);
        if (opcode == OP_LW) begin
          rf_wdata = mdr_q;
        end else if (opcode == OP_JAL) begin
          rf_wdata = pc_q + 32'd4;
        end else begin
          rf_wdata = alu_q;
        end
        pc_d    = (opcode == OP_JAL) ? (pc_q + imm_q) : (pc_q + 32'd4);
        retire  = 1'b1;
        state_d = (rd == HALT_IDX) ? S_HALT : S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase

    instret_d = instret_q + {31'b0, retire};
  end

  // Sequencer state and registered intermediates
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q   <= S_IF;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      instret_q <= instret_d;
    end
  end

  // Register file: cleared on reset, x0 is never written
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Data memory store port; contents survive reset
  always_ff @(posedge w_clk) begin
    if (dmem_we) begin
      dmem[dmem_idx] <= b_q;
    end
  end

  assign w_pc      = pc_q;
  assign w_retire  = retire;
  assign w_instret = instret_q;
  assign w_halt    = (state_q == S_HALT);

endmodule

// File: tb/tb_m_proc_mc.sv
// Directed bench for the multi-cycle core: a table of small programs with
// hand-computed results, plus sequences for retire timing, halt, async reset
// in the middle of a load, and a second instance with a non-zero reset PC.
module tb_m_proc_mc;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        retire;
  logic [31:0] instret;
  logic        halt;

  logic        rst2_n;
  logic [31:0] pc2;
  logic        retire2;
  logic [31:0] instret2;
  logic        halt2;

  int nvec;
  int nerr;

  typedef struct {
    string       name;
    logic [31:0] p0, p1, p2, p3, p4;
    int          cycles;
    int          chk_reg;
    logic [31:0] exp_reg;
    logic [31:0] exp_pc;
    logic [31:0] exp_instret;
  } vec_t;

  vec_t vecs[$];

  m_proc_mc dut (
    .w_clk     (clk),
    .w_rst_n   (rst_n),
    .w_pc      (pc),
    .w_retire  (retire),
    .w_instret (instret),
    .w_halt    (halt)
  );

  m_proc_mc #(
    .IMEM_DEPTH (16),
    .DMEM_DEPTH (64),
    .RESET_PC   (32'h40),
    .HALT_REG   (30)
  ) dut2 (
    .w_clk     (clk),
    .w_rst_n   (rst2_n),
    .w_pc      (pc2),
    .w_retire  (retire2),
    .w_instret (instret2),
    .w_halt    (halt2)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] f_addi(input logic [31:0] rd, input logic [31:0] rs1, input logic [31:0] imm);
    return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
  endfunction

  function automatic logic [31:0] f_rtype(input logic [31:0] f7, input logic [31:0] f3, input logic [31:0] rd,
                                          input logic [31:0] rs1, input logic [31:0] rs2);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] f_lw(input logic [31:0] rd, input logic [31:0] rs1, input logic [31:0] imm);
    return {imm[11:0], rs1[4:0], 3'b010, rd[4:0], 7'b0000011};
  endfunction

  function automatic logic [31:0] f_sw(input logic [31:0] rs2, input logic [31:0] rs1, input logic [31:0] imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] f_br(input logic [31:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                                       input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] f_jal(input logic [31:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  function automatic logic [31:0] f_lui(input logic [31:0] rd, input logic [31:0] imm20);
    return {imm20[19:0], rd[4:0], 7'b0110111};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                         input logic [31:0] p3, input logic [31:0] p4, input int cycles, input int chk_reg,
                         input logic [31:0] exp_reg, input logic [31:0] exp_pc, input logic [31:0] exp_instret);
    vec_t v;
    v.name = name;
    v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3; v.p4 = p4;
    v.cycles = cycles;
    v.chk_reg = chk_reg;
    v.exp_reg = exp_reg;
    v.exp_pc = exp_pc;
    v.exp_instret = exp_instret;
    vecs.push_back(v);
  endtask

  // Hold reset, load a program into the main instance, release mid-cycle
  task automatic load_program(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                              input logic [31:0] p3, input logic [31:0] p4);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) dut.imem[i] = 32'h0;
    dut.imem[0] = p0;
    dut.imem[1] = p1;
    dut.imem[2] = p2;
    dut.imem[3] = p3;
    dut.imem[4] = p4;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input vec_t v);
    load_program(v.p0, v.p1, v.p2, v.p3, v.p4);
    run_cycles(v.cycles);
    check_output({v.name, " reg"}, dut.rf_q[v.chk_reg], v.exp_reg);
    check_output({v.name, " pc"}, pc, v.exp_pc);
    check_output({v.name, " instret"}, instret, v.exp_instret);
  endtask

  initial begin
    nvec   = 0;
    nerr   = 0;
    rst_n  = 1'b0;
    rst2_n = 1'b0;

    add_vec("add", f_addi(1, 0, 5), f_addi(2, 0, 7), f_rtype(0, 0, 3, 1, 2), f_rtype(32, 0, 4, 1, 2), 0,
            16, 3, 32'd12, 32'd16, 32'd4);
    add_vec("sub", f_addi(1, 0, 5), f_addi(2, 0, 7), f_rtype(0, 0, 3, 1, 2), f_rtype(32, 0, 4, 1, 2), 0,
            16, 4, 32'hFFFF_FFFE, 32'd16, 32'd4);
    add_vec("and", f_addi(1, 0, 12), f_addi(2, 0, 10), f_rtype(0, 7, 3, 1, 2), 0, 0,
            12, 3, 32'd8, 32'd12, 32'd3);
    add_vec("or", f_addi(1, 0, 12), f_addi(2, 0, 10), f_rtype(0, 6, 3, 1, 2), 0, 0,
            12, 3, 32'd14, 32'd12, 32'd3);
    add_vec("slt_true", f_addi(1, 0, 32'hFFF), f_addi(2, 0, 1), f_rtype(0, 2, 3, 1, 2), 0, 0,
            12, 3, 32'd1, 32'd12, 32'd3);
    add_vec("slt_false", f_addi(1, 0, 32'hFFF), f_addi(2, 0, 1), f_rtype(0, 2, 3, 2, 1), 0, 0,
            12, 3, 32'd0, 32'd12, 32'd3);
    add_vec("lui", f_lui(7, 32'h12345), 0, 0, 0, 0,
            4, 7, 32'h1234_5000, 32'd4, 32'd1);
    add_vec("sw_lw", f_addi(1, 0, 42), f_sw(1, 0, 8), f_lw(5, 0, 8), 0, 0,
            13, 5, 32'd42, 32'd12, 32'd3);
    add_vec("sw_wrap", f_addi(1, 0, 77), f_sw(1, 0, 256), f_lw(6, 0, 0), 0, 0,
            13, 6, 32'd77, 32'd12, 32'd3);
    add_vec("beq_taken", f_br(0, 0, 0, 8), f_addi(1, 0, 1), f_addi(2, 0, 3), 0, 0,
            7, 2, 32'd3, 32'd12, 32'd2);
    add_vec("beq_skip", f_br(0, 0, 0, 8), f_addi(1, 0, 1), f_addi(2, 0, 3), 0, 0,
            7, 1, 32'd0, 32'd12, 32'd2);
    add_vec("bne_not_taken", f_br(1, 0, 0, 8), f_addi(1, 0, 9), 0, 0, 0,
            7, 1, 32'd9, 32'd8, 32'd2);
    add_vec("bne_taken", f_addi(1, 0, 1), f_br(1, 1, 0, 8), f_addi(2, 0, 5), f_addi(3, 0, 6), 0,
            11, 3, 32'd6, 32'd16, 32'd3);
    add_vec("bne_skip", f_addi(1, 0, 1), f_br(1, 1, 0, 8), f_addi(2, 0, 5), f_addi(3, 0, 6), 0,
            11, 2, 32'd0, 32'd16, 32'd3);
    add_vec("jal", 0, 0, 0, 0, f_jal(1, 12),
            16, 1, 32'd20, 32'd28, 32'd5);
    add_vec("x0_write", f_addi(0, 0, 5), 0, 0, 0, 0,
            4, 0, 32'd0, 32'd4, 32'd1);

    // Reset state of the main instance
    @(negedge clk);
    check_output("reset pc", pc, 32'h0);
    check_output("reset retire", {31'b0, retire}, 32'd0);
    check_output("reset instret", instret, 32'd0);
    check_output("reset halt", {31'b0, halt}, 32'd0);
    check_output("reset pc2", pc2, 32'h40);

    foreach (vecs[k]) apply_stimulus(vecs[k]);

    // Retire pulse lands in the last cycle of each 4-cycle instruction
    load_program(f_addi(1, 0, 5), f_addi(2, 0, 7), f_rtype(0, 0, 3, 1, 2), f_rtype(32, 0, 4, 1, 2), 0);
    for (int c = 1; c <= 16; c++) begin
      check_output($sformatf("arith retire c%0d", c), {31'b0, retire}, ((c % 4) == 0) ? 32'd1 : 32'd0);
      run_cycles(1);
    end

    // lw takes five cycles: retire at 4, 8 and 13
    load_program(f_addi(1, 0, 42), f_sw(1, 0, 8), f_lw(5, 0, 8), 0, 0);
    for (int c = 1; c <= 13; c++) begin
      check_output($sformatf("mem retire c%0d", c), {31'b0, retire},
                   ((c == 4) || (c == 8) || (c == 13)) ? 32'd1 : 32'd0);
      run_cycles(1);
    end
    check_output("mem dmem2", dut.dmem[2], 32'd42);

    // Halt on write-back to x30, then everything freezes
    load_program(f_addi(30, 0, 1), f_addi(1, 0, 3), 0, 0, 0);
    run_cycles(3);
    check_output("halt before", {31'b0, halt}, 32'd0);
    run_cycles(1);
    check_output("halt set", {31'b0, halt}, 32'd1);
    check_output("halt pc", pc, 32'd4);
    check_output("halt instret", instret, 32'd1);
    check_output("halt x30", dut.rf_q[30], 32'd1);
    for (int c = 0; c < 20; c++) begin
      run_cycles(1);
      if (retire !== 1'b0) begin
        nerr++;
        $display("[TB] FAIL halt retire: got %b, expected 0", retire);
      end
      nvec++;
    end
    check_output("halt frozen pc", pc, 32'd4);
    check_output("halt frozen instret", instret, 32'd1);
    check_output("halt frozen x1", dut.rf_q[1], 32'd0);
    check_output("halt sticky", {31'b0, halt}, 32'd1);

    // Async reset while the lw sits in S_MA aborts it
    load_program(f_addi(1, 0, 42), f_sw(1, 0, 8), f_lw(5, 0, 8), 0, 0);
    run_cycles(11);
    check_output("abort pre instret", instret, 32'd2);
    check_output("abort pre retire", {31'b0, retire}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_output("abort pc", pc, 32'h0);
    check_output("abort retire", {31'b0, retire}, 32'd0);
    check_output("abort instret", instret, 32'd0);
    check_output("abort x5", dut.rf_q[5], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cycles(13);
    check_output("restart x5", dut.rf_q[5], 32'd42);
    check_output("restart pc", pc, 32'd12);
    check_output("restart instret", instret, 32'd3);

    // Second instance: reset PC 0x40 wraps to imem[0] in a 16-word IMEM
    rst2_n = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) dut2.imem[i] = 32'h0;
    dut2.imem[0] = f_addi(1, 0, 32'hFFF);
    dut2.imem[1] = f_addi(2, 0, 1);
    dut2.imem[2] = f_rtype(0, 2, 6, 1, 2);
    @(negedge clk);
    rst2_n = 1'b1;
    run_cycles(12);
    check_output("p2 x6", dut2.rf_q[6], 32'd1);
    check_output("p2 x1", dut2.rf_q[1], 32'hFFFF_FFFF);
    check_output("p2 pc", pc2, 32'h4C);
    check_output("p2 instret", instret2, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
